evg_soft_event_gen: RTL and testbench

//  Event-generator side of the soft-event path: converts software event requests and the
//  1Hz booster/SR trigger into a serialized stream of event codes for the event link.

---
 rtl/evg_soft_event_gen.sv | 198 +++++++++++++++++++
 tb/tb_evg_soft_event_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evg_soft_event_gen.sv
// Soft-event generator: queues software event codes and the 1Hz trigger code into a
// serialized, holdoff-spaced event-code stream. Optional loopback pulse: SOFT_EVT_LOOPBACK_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for trig_pend or a queued soft request
// SEND  | tx_valid high, tx_code held until tx_ready handshake
// HOLD  | enforcing HOLDOFF idle cycles after an accepted code
module evg_soft_event_gen #(
    parameter int         FIFO_AW       = 2,
    parameter logic [7:0] SOFT_EVT_CODE = 8'h70,
    parameter logic [7:0] TRIG_EVT_CODE = 8'h7D,
    parameter int         HOLDOFF       = 4,
    parameter int         STRETCH       = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_enable,
    input  logic                sw_req,
    input  logic [7:0]          sw_code,
    input  logic                evg_trig,
    input  logic [63:0]         evr_TS,
    input  logic                tx_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_code,
    output logic [63:0]         tx_TS,
    output logic [FIFO_AW:0]    fifo_level,
    output logic [31:0]         sent_count,
    output logic [15:0]         drop_count,
    output logic                soft_event_out
);

    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam int              HW       = $clog2(HOLDOFF + 1);
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    if (HOLDOFF < 1 || STRETCH < 1 || SOFT_EVT_CODE == TRIG_EVT_CODE) begin : g_bad_param
        $error("evg_soft_event_gen: HOLDOFF/STRETCH must be >= 1 and event codes distinct");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              trig_s1, trig_s2, trig_s3;
    logic              trig_edge;
    logic              trig_pend;
    logic              load_trig, pop, handshake;
    logic              push, drop, full;
    logic [HW-1:0]     hold_cnt;
    logic [7:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;

    // Synchronizer and edge detector keep running while clk_enable is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= evg_trig;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    assign trig_edge = trig_s2 & ~trig_s3;

    // A new edge wins over a same-cycle consume so it is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            trig_pend <= 1'b0;
        else if (trig_edge)
            trig_pend <= 1'b1;
        else if (load_trig)
            trig_pend <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_trig = 1'b0;
        pop       = 1'b0;
        handshake = 1'b0;
        if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (trig_pend) begin
                        load_trig = 1'b1;
                        state_nxt = SEND;
                    end else if (fifo_level != '0) begin
                        pop       = 1'b1;
                        state_nxt = SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        handshake = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign tx_valid = (state == SEND);

    // Holdoff down-counter: HOLDOFF cycles in HOLD, terminal count at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hold_cnt <= '0;
        else if (handshake)
            hold_cnt <= HW'(HOLDOFF - 1);
        else if (clk_enable && state == HOLD && hold_cnt != '0)
            hold_cnt <= hold_cnt - HW'(1);
    end

    assign full = (fifo_level == FULL_LVL);
    assign push = sw_req & clk_enable & (~full | pop);
    assign drop = sw_req & clk_enable & full & ~pop;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sw_code;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && !pop)
                fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
            else if (pop && !push)
                fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_code    <= 8'h00;
            tx_TS      <= 64'h0;
            sent_count <= 32'h0;
            drop_count <= 16'h0;
        end else begin
            if (load_trig)
                tx_code <= TRIG_EVT_CODE;
            else if (pop)
                tx_code <= mem[rd_ptr];
            if (handshake) begin
                tx_TS      <= evr_TS;
                sent_count <= sent_count + 32'd1;
            end
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

`ifdef SOFT_EVT_LOOPBACK_EN
    localparam int SW = $clog2(STRETCH + 1);

    logic [SW-1:0] stretch_cnt;

    // Reload on every soft-code handshake so a retrigger restarts the full width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stretch_cnt <= '0;
        else if (handshake && tx_code == SOFT_EVT_CODE)
            stretch_cnt <= SW'(STRETCH);
        else if (clk_enable && stretch_cnt != '0)
            stretch_cnt <= stretch_cnt - SW'(1);
    end

    assign soft_event_out = (stretch_cnt != '0);
`else
    assign soft_event_out = 1'b0;
`endif

endmodule

// File: tb/tb_evg_soft_event_gen.sv
// Directed bench for evg_soft_event_gen: a per-cycle vector table for the basic send
// path, then hand-written sequences for queueing, priority, freeze and reset cases.
module tb_evg_soft_event_gen;

    localparam int HOLDOFF = 4;
    localparam int STRETCH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_enable = 1'b1;
    logic        sw_req = 1'b0;
    logic [7:0]  sw_code = 8'h00;
    logic        evg_trig = 1'b0;
    logic [63:0] evr_TS = 64'h0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_code;
    logic [63:0] tx_TS;
    logic [2:0]  fifo_level;
    logic [31:0] sent_count;
    logic [15:0] drop_count;
    logic        soft_event_out;

    evg_soft_event_gen #(
        .FIFO_AW(2), .SOFT_EVT_CODE(8'h70), .TRIG_EVT_CODE(8'h7D),
        .HOLDOFF(HOLDOFF), .STRETCH(STRETCH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable),
        .sw_req(sw_req), .sw_code(sw_code), .evg_trig(evg_trig), .evr_TS(evr_TS),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_code(tx_code), .tx_TS(tx_TS),
        .fifo_level(fifo_level), .sent_count(sent_count), .drop_count(drop_count),
        .soft_event_out(soft_event_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int exp_sent = 0;
    int exp_drop = 0;
    int last_hs = 0;

    typedef struct {
        logic       req;
        logic [7:0] code;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_code;
        logic [2:0] exp_level;
        logic [31:0] exp_sent;
        logic       chk_ts;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Waits for tx_valid with tx_ready high, checks the code and the spacing from the
    // previous handshake, then lets the handshake edge pass.
    task automatic expect_send(input logic [7:0] code, input string nm, input bit chk_gap);
        int n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 60) begin
            step();
            n++;
        end
        check({nm, " valid"}, 64'(tx_valid), 64'd1);
        if (tx_valid) begin
            check({nm, " code"}, 64'(tx_code), 64'(code));
            if (chk_gap)
                check({nm, " gap"}, 64'(cyc - last_hs), 64'(HOLDOFF + 2));
            last_hs = cyc;
            step();
            exp_sent++;
            check({nm, " sent_count"}, 64'(sent_count), 64'(exp_sent));
            check({nm, " valid drop"}, 64'(tx_valid), 64'd0);
        end
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_valid) seen++;
            step();
        end
    endtask

    initial begin
        logic [63:0] exp_ts;
        int          seen;
        int          width;

        tbl[0]  = '{1'b1, 8'h70, 1'b1, 1'b0, 8'h00, 3'd1, 32'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h70, 3'd0, 32'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h70, 3'd1, 32'd1, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h70, 3'd1, 32'd1, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h70, 3'd1, 32'd1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h70, 3'd1, 32'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h70, 3'd1, 32'd1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 3'd0, 32'd1, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 3'd0, 32'd1, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 3'd0, 32'd1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 3'd0, 32'd2, 1'b1};

        // Reset state
        idle_wait(3);
        check("rst tx_valid", 64'(tx_valid), 64'd0);
        check("rst fifo_level", 64'(fifo_level), 64'd0);
        reset_n = 1'b1;
        step();
        check("rst tx_code", 64'(tx_code), 64'd0);
        check("rst tx_TS", tx_TS, 64'd0);
        check("rst sent_count", 64'(sent_count), 64'd0);
        check("rst drop_count", 64'(drop_count), 64'd0);
        check("rst soft_event_out", 64'(soft_event_out), 64'd0);

        // Single request, two-cycle latency, holdoff, stall, timestamp
        exp_ts = 64'h0;
        for (int i = 0; i < 11; i++) begin
            sw_req   = tbl[i].req;
            sw_code  = tbl[i].code;
            tx_ready = tbl[i].ready;
            evr_TS   = 64'hA5A5_0000_0000_0000 + 64'(i);
            step();
            if (tbl[i].chk_ts) exp_ts = 64'hA5A5_0000_0000_0000 + 64'(i);
            check($sformatf("vec%0d tx_valid", i), 64'(tx_valid), 64'(tbl[i].exp_valid));
            check($sformatf("vec%0d tx_code", i), 64'(tx_code), 64'(tbl[i].exp_code));
            check($sformatf("vec%0d fifo_level", i), 64'(fifo_level), 64'(tbl[i].exp_level));
            check($sformatf("vec%0d sent_count", i), 64'(sent_count), 64'(tbl[i].exp_sent));
            check($sformatf("vec%0d tx_TS", i), tx_TS, exp_ts);
        end
        exp_sent = 2;
        sw_req = 1'b0;
        tx_ready = 1'b1;
        idle_wait(8);

        // Fill FIFO behind a stalled SEND, overflow, then push+pop on full
        tx_ready = 1'b0;
        sw_req = 1'b1; sw_code = 8'h01;
        step();
        sw_req = 1'b0;
        step();
        check("t2 stalled valid", 64'(tx_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            sw_req = 1'b1;
            sw_code = 8'(8'h11 * (k + 1));
            step();
        end
        sw_req = 1'b0;
        exp_drop = 1;
        check("t2 level full", 64'(fifo_level), 64'd4);
        check("t2 drop", 64'(drop_count), 64'(exp_drop));
        expect_send(8'h01, "t2 c01", 1'b0);
        idle_wait(HOLDOFF);
        sw_req = 1'b1; sw_code = 8'h66;
        step();
        sw_req = 1'b0;
        check("t2 full push+pop level", 64'(fifo_level), 64'd4);
        check("t2 full push+pop drop", 64'(drop_count), 64'(exp_drop));
        expect_send(8'h11, "t2 c11", 1'b1);
        expect_send(8'h22, "t2 c22", 1'b1);
        expect_send(8'h33, "t2 c33", 1'b1);
        expect_send(8'h44, "t2 c44", 1'b1);
        expect_send(8'h66, "t2 c66", 1'b1);
        check("t2 level empty", 64'(fifo_level), 64'd0);
        idle_wait(8);

        // Synced trigger edge coincident with sw_req: trigger code first, 4-cycle latency
        evg_trig = 1'b1;
        step();
        check("t3 lat1", 64'(tx_valid), 64'd0);
        step();
        sw_req = 1'b1; sw_code = 8'h5A;
        step();
        sw_req = 1'b0;
        check("t3 lat3", 64'(tx_valid), 64'd0);
        step();
        check("t3 lat4", 64'(tx_valid), 64'd1);
        evg_trig = 1'b0;
        expect_send(8'h7D, "t3 trig", 1'b0);
        expect_send(8'h5A, "t3 soft", 1'b1);
        idle_wait(8);

        // Two trigger edges during a stalled SEND merge into one trigger code
        tx_ready = 1'b0;
        sw_req = 1'b1; sw_code = 8'h21;
        step();
        sw_req = 1'b0;
        step();
        for (int r = 0; r < 2; r++) begin
            evg_trig = 1'b1;
            idle_wait(3);
            evg_trig = 1'b0;
            idle_wait(3);
        end
        idle_wait(2);
        expect_send(8'h21, "t4 c21", 1'b0);
        expect_send(8'h7D, "t4 trig", 1'b1);
        count_valid(20, seen);
        check("t4 extra sends", 64'(seen), 64'd0);

        // clk_enable low mid-SEND: frozen, no push, trigger still captured
        tx_ready = 1'b0;
        sw_req = 1'b1; sw_code = 8'h42;
        step();
        sw_req = 1'b0;
        step();
        clk_enable = 1'b0;
        tx_ready = 1'b1;
        sw_req = 1'b1; sw_code = 8'hEE;
        evg_trig = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t5 frz%0d valid", i), 64'(tx_valid), 64'd1);
            check($sformatf("t5 frz%0d code", i), 64'(tx_code), 64'h42);
        end
        sw_req = 1'b0;
        evg_trig = 1'b0;
        check("t5 frozen sent", 64'(sent_count), 64'(exp_sent));
        check("t5 frozen level", 64'(fifo_level), 64'd0);
        check("t5 frozen drop", 64'(drop_count), 64'(exp_drop));
        clk_enable = 1'b1;
        expect_send(8'h42, "t5 c42", 1'b0);
        expect_send(8'h7D, "t5 trig", 1'b1);
        idle_wait(8);

        // Loopback pulse width after a soft-code send
        sw_req = 1'b1; sw_code = 8'h70;
        step();
        sw_req = 1'b0;
        expect_send(8'h70, "t6 c70", 1'b0);
        width = 0;
        for (int i = 0; i < 10; i++) begin
            if (soft_event_out) width++;
            step();
        end
`ifdef SOFT_EVT_LOOPBACK_EN
        check("t6 soft width", 64'(width), 64'(STRETCH));
`else
        check("t6 soft width", 64'(width), 64'd0);
`endif

        // Reset mid-SEND with three queued codes
        tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sw_req = 1'b1;
            sw_code = 8'(8'hA1 + k);
            step();
        end
        sw_req = 1'b0;
        check("t6 pre-rst valid", 64'(tx_valid), 64'd1);
        check("t6 pre-rst level", 64'(fifo_level), 64'd3);
        reset_n = 1'b0;
        #2;
        check("t6 rst valid", 64'(tx_valid), 64'd0);
        check("t6 rst level", 64'(fifo_level), 64'd0);
        exp_sent = 0;
        exp_drop = 0;
        check("t6 rst sent", 64'(sent_count), 64'(exp_sent));
        idle_wait(2);
        reset_n = 1'b1;
        tx_ready = 1'b1;
        count_valid(12, seen);
        check("t6 discarded", 64'(seen), 64'd0);
        sw_req = 1'b1; sw_code = 8'h0F;
        step();
        sw_req = 1'b0;
        expect_send(8'h0F, "t6 after rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
